block_path_stepper: RTL
=======================

# block_path_stepper

Parametrised successor to the Klotski block-movement motor driver, sitting between the solver's move sequencer and the XY-gantry stepper drivers. It accepts one move request as a start cell and an end cell on a COLS×ROWS board. It keeps track of the gantry head position, moves the head to the start cell with the magnet off, grabs the block, carries it to the end cell, releases it, and pulses done.

## Interface
Parameters:
- COLS, 4, board columns
- ROWS, 5, board rows
- CELL_W, $clog2(COLS*ROWS), cell index width
- STEPS_PER_CELL, 200, step pulses per cell pitch
- HALF_PERIOD, 25000, clock cycles per step-pulse phase (≥1)
- SETTLE_CYCLES, 2500000, magnet settle time in cycles (≥1)
- RAMP_STEPS, 16, slow steps at the start of each leg (only with ramp enabled)

Ports:
- i_Clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  request strobe, sampled only in IDLE
- i_Start_Block  in  CELL_W  source cell, index = row*COLS + col
- i_End_Block  in  CELL_W  destination cell
- o_step_control_x / o_step_control_y  out  1  step pulse per axis
- o_direction_x / o_direction_y  out  1  1 = increasing col/row
- o_magnet  out  1  electromagnet enable
- o_busy  out  1  high whenever state ≠ IDLE
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  one-cycle pulse when a request is rejected

## Operation
- Registered head position (col, row), reset to (0,0).
- States: IDLE → TRAVEL_X → TRAVEL_Y → GRAB → CARRY_X → CARRY_Y → RELEASE → DONE → IDLE.
- IDLE: on i_en, latch both indices.
  - If either index ≥ COLS*ROWS: pulse o_err for one cycle, stay IDLE, and move nothing.
  - Otherwise go to TRAVEL_X.
- TRAVEL legs run from the head position to the start cell with o_magnet=0.
- CARRY legs run from the start cell to the end cell with o_magnet=1.
- Leg length is |Δ|*STEPS_PER_CELL pulses.
- Direction is registered on leg entry: 1 if Δ>0, else 0. A leg with Δ=0 is skipped in one cycle with no pulses.
- GRAB: o_magnet rises on entry; hold SETTLE_CYCLES.
- RELEASE: o_magnet falls on entry; hold SETTLE_CYCLES.
- DONE: o_done=1 for one cycle, and the head position updates to the end cell.
- Start == end is legal: travel, then grab, zero carry, release, done.
- i_en while busy is ignored, with no queueing.
- Reset mid-operation: all outputs go to 0 immediately, the magnet drops, the head position returns to (0,0), and the mechanism must be re-homed externally.
- Only one axis pulses at a time.

## Timing
- Reset value of every output is 0.
- Step pulse: the leg begins low for HALF_PERIOD, then high for HALF_PERIOD; repeat per step.
- The first rising edge comes HALF_PERIOD cycles after leg entry, so direction has one full half-period of setup.
- Leg duration is N*2*HALF_PERIOD cycles. The leg ends on the cycle its last high phase ends, and the step output returns to 0 in the next state.
- Direction holds until the next non-skipped leg entry.
- Step counter width is $clog2(max(COLS,ROWS)*STEPS_PER_CELL + 1).
- Phase counter width is $clog2(2*HALF_PERIOD).
- o_busy rises the cycle after an accepted i_en and falls with o_done.
- o_err and o_done are mutually exclusive.

## Configuration
- STEPPER_RAMP_EN defined:
  - The first min(RAMP_STEPS, N) pulses of each non-skipped leg use phase length 2*HALF_PERIOD.
  - The remaining pulses use HALF_PERIOD.
  - Pulse counts are unchanged.
- STEPPER_RAMP_EN undefined: all pulses use HALF_PERIOD, and RAMP_STEPS is unused.

## Structure
- Package block_path_stepper_pkg holds:
  - the state enum
  - the axis enum
  - a function splitting an index into (col, row) via COLS
- Sub-module stepper_leg, instantiated once and shared by all four legs:
  - inputs: start, count, dir
  - outputs: step, dir, leg_done
  - contains the phase and step counters and the ramp logic

## Test plan
Bench parameters: COLS=4, ROWS=5, STEPS_PER_CELL=2, HALF_PERIOD=2, SETTLE_CYCLES=3, RAMP_STEPS=1.

- After reset, request 0→1:
  - travel is skipped
  - magnet goes high for the carry
  - X gives 2 pulses with dir=1, Y gives 0 pulses
  - o_done pulses once; cycle count is checked
- Head at 1, request 6→10:
  - travel gives X 2 pulses dir=1, then Y 2 pulses dir=1, magnet 0
  - carry gives Y 2 pulses dir=1 with magnet 1, X 0 pulses
- Head at 10, request 7→6:
  - travel gives X 2 pulses dir=1, then Y 2 pulses dir=0
  - carry gives X 2 pulses dir=0
- Request 20→3:
  - o_err pulses once with no step pulses, and o_busy stays 0
  - i_en pulsed during a carry is ignored
- Reset asserted mid-CARRY_X:
  - all outputs go to 0 asynchronously
  - a following 0→1 behaves exactly as from power-up
- With STEPPER_RAMP_EN, request 0→1:
  - the first X pulse is 4 cycles high and the second is 2 cycles high

Source files
------------

// File: rtl/block_path_stepper_pkg.sv
// Shared types for the block path stepper: FSM states, axis selector and
// board-index to (col, row) conversion.
package block_path_stepper_pkg;

  localparam int COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t col;
    coord_t row;
  } cell_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAVEL_X,
    S_TRAVEL_Y,
    S_GRAB,
    S_CARRY_X,
    S_CARRY_Y,
    S_RELEASE,
    S_DONE
  } state_e;

  typedef enum logic {
    AXIS_X,
    AXIS_Y
  } axis_e;

  function automatic cell_t split_cell(input coord_t idx, input coord_t cols);
    cell_t c;
    c.col = idx % cols;
    c.row = idx / cols;
    return c;
  endfunction

endpackage

// File: rtl/block_path_stepper_leg.sv
// One stepper leg: low/high half-periods per step, N steps, latched direction.
// STEPPER_RAMP_EN doubles the phase length for the first RAMP_STEPS pulses.
module stepper_leg #(
  parameter int HALF_PERIOD = 25000,
  parameter int RAMP_STEPS  = 16,
  parameter int STEP_W      = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [STEP_W-1:0] count_i,
  input  logic              dir_i,
  output logic              step_o,
  output logic              dir_o,
  output logic              leg_done_o
);

  localparam int PH_W = $clog2(2 * HALF_PERIOD);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(HALF_PERIOD);
`ifdef STEPPER_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  logic              active_q, dir_q, step_q, tick_q;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [STEP_W-1:0] steps_q, ramp_q, ramp_load;
  logic              slow, adv, wrap;

  // During ramp the phase counter advances every other cycle, doubling each phase.
  assign ramp_load  = !RAMP_EN ? '0 :
                      (int'(count_i) < RAMP_STEPS) ? count_i : STEP_W'(RAMP_STEPS);
  assign slow       = (ramp_q != '0);
  assign adv        = !slow || tick_q;
  assign wrap       = adv && (phase_q == PH_LAST);
  assign phase_d    = !adv ? phase_q : (wrap ? '0 : phase_q + PH_W'(1));
  assign leg_done_o = active_q && wrap && (steps_q == STEP_W'(1));
  assign step_o     = step_q;
  assign dir_o      = dir_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      tick_q   <= 1'b0;
      phase_q  <= '0;
      steps_q  <= '0;
      ramp_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      dir_q    <= dir_i;
      step_q   <= 1'b0;
      tick_q   <= 1'b0;
      phase_q  <= '0;
      steps_q  <= count_i;
      ramp_q   <= ramp_load;
    end else if (active_q) begin
      phase_q <= phase_d;
      step_q  <= (phase_d >= PH_HIGH);
      tick_q  <= slow && !tick_q;
      if (wrap) begin
        steps_q <= steps_q - STEP_W'(1);
        if (slow) ramp_q <= ramp_q - STEP_W'(1);
      end
      if (leg_done_o) begin
        active_q <= 1'b0;
        step_q   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/block_path_stepper.sv
// Gantry move controller: travel to start cell, grab, carry to end cell, release.
// Optional acceleration ramp in the shared leg when STEPPER_RAMP_EN is defined.
module block_path_stepper
  import block_path_stepper_pkg::*;
#(
  parameter int COLS           = 4,
  parameter int ROWS           = 5,
  parameter int CELL_W         = $clog2(COLS * ROWS),
  parameter int STEPS_PER_CELL = 200,
  parameter int HALF_PERIOD    = 25000,
  parameter int SETTLE_CYCLES  = 2500000,
  parameter int RAMP_STEPS     = 16
) (
  input  logic              i_Clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [CELL_W-1:0] i_Start_Block,
  input  logic [CELL_W-1:0] i_End_Block,
  output logic              o_step_control_x,
  output logic              o_step_control_y,
  output logic              o_direction_x,
  output logic              o_direction_y,
  output logic              o_magnet,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int MAX_DIM = (COLS > ROWS) ? COLS : ROWS;
  localparam int STEP_W  = $clog2(MAX_DIM * STEPS_PER_CELL + 1);
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int N_CELLS = COLS * ROWS;

  state_e            state_q;
  cell_t             head_q, start_q, end_q, in_start, in_end;
  logic [SET_W-1:0]  settle_q;
  logic              skip_q, magnet_q, busy_q, done_q, err_q;
  axis_e             leg_axis_q;
  logic              hold_x_q, hold_y_q;

  logic              req_ok, settle_end, leg_fin;
  logic              plan_vld;
  axis_e             plan_axis;
  coord_t            plan_from, plan_to, plan_dist;
  logic              leg_start, leg_dir_d, leg_step, leg_dir, leg_done;
  logic [STEP_W-1:0] leg_count;

  assign in_start   = split_cell(COORD_W'(i_Start_Block), COORD_W'(COLS));
  assign in_end     = split_cell(COORD_W'(i_End_Block), COORD_W'(COLS));
  assign req_ok     = (int'(i_Start_Block) < N_CELLS) && (int'(i_End_Block) < N_CELLS);
  assign settle_end = (settle_q == '0);
  assign leg_fin    = skip_q || leg_done;

  // Leg command for the state being entered, so the leg starts on state entry.
  always_comb begin
    plan_vld  = 1'b0;
    plan_axis = AXIS_X;
    plan_from = '0;
    plan_to   = '0;
    case (state_q)
      S_IDLE:     if (i_en && req_ok) begin
                    plan_vld = 1'b1; plan_axis = AXIS_X;
                    plan_from = head_q.col; plan_to = in_start.col;
                  end
      S_TRAVEL_X: if (leg_fin) begin
                    plan_vld = 1'b1; plan_axis = AXIS_Y;
                    plan_from = head_q.row; plan_to = start_q.row;
                  end
      S_GRAB:     if (settle_end) begin
                    plan_vld = 1'b1; plan_axis = AXIS_X;
                    plan_from = start_q.col; plan_to = end_q.col;
                  end
      S_CARRY_X:  if (leg_fin) begin
                    plan_vld = 1'b1; plan_axis = AXIS_Y;
                    plan_from = start_q.row; plan_to = end_q.row;
                  end
      default: ;
    endcase
  end

  assign plan_dist = (plan_to > plan_from) ? plan_to - plan_from : plan_from - plan_to;
  assign leg_start = plan_vld && (plan_to != plan_from);
  assign leg_dir_d = (plan_to > plan_from);
  assign leg_count = STEP_W'(plan_dist * STEPS_PER_CELL);

  stepper_leg #(
    .HALF_PERIOD (HALF_PERIOD),
    .RAMP_STEPS  (RAMP_STEPS),
    .STEP_W      (STEP_W)
  ) u_leg (
    .clk_i      (i_Clk),
    .rst_ni     (i_rst_n),
    .start_i    (leg_start),
    .count_i    (leg_count),
    .dir_i      (leg_dir_d),
    .step_o     (leg_step),
    .dir_o      (leg_dir),
    .leg_done_o (leg_done)
  );

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      start_q    <= '0;
      end_q      <= '0;
      settle_q   <= '0;
      skip_q     <= 1'b0;
      magnet_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      leg_axis_q <= AXIS_X;
      hold_x_q   <= 1'b0;
      hold_y_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (plan_vld) skip_q <= !leg_start;
      // The shared leg only remembers the latest direction; park the other axis's.
      if (leg_start) begin
        if (plan_axis != leg_axis_q) begin
          if (leg_axis_q == AXIS_X) hold_x_q <= leg_dir;
          else                      hold_y_q <= leg_dir;
        end
        leg_axis_q <= plan_axis;
      end
      case (state_q)
        S_IDLE: if (i_en) begin
          if (req_ok) begin
            start_q <= in_start;
            end_q   <= in_end;
            busy_q  <= 1'b1;
            state_q <= S_TRAVEL_X;
          end else begin
            err_q <= 1'b1;
          end
        end
        S_TRAVEL_X: if (leg_fin) state_q <= S_TRAVEL_Y;
        S_TRAVEL_Y: if (leg_fin) begin
          state_q  <= S_GRAB;
          magnet_q <= 1'b1;
          settle_q <= SET_W'(SETTLE_CYCLES - 1);
        end
        S_GRAB: if (settle_end) state_q <= S_CARRY_X;
                else            settle_q <= settle_q - SET_W'(1);
        S_CARRY_X: if (leg_fin) state_q <= S_CARRY_Y;
        S_CARRY_Y: if (leg_fin) begin
          state_q  <= S_RELEASE;
          magnet_q <= 1'b0;
          settle_q <= SET_W'(SETTLE_CYCLES - 1);
        end
        S_RELEASE: if (settle_end) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end else begin
          settle_q <= settle_q - SET_W'(1);
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          head_q  <= end_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_step_control_x = leg_step && (leg_axis_q == AXIS_X);
  assign o_step_control_y = leg_step && (leg_axis_q == AXIS_Y);
  assign o_direction_x    = (leg_axis_q == AXIS_X) ? leg_dir : hold_x_q;
  assign o_direction_y    = (leg_axis_q == AXIS_Y) ? leg_dir : hold_y_q;
  assign o_magnet         = magnet_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_err            = err_q;

endmodule
